// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline datapaths.
//   - ALU control codes consumed by the ALU
//   - ALUOp encodings produced by the main decoder
//   - R-type funct field values
//   - Forwarding-select encodings used by the EX-stage operand muxes
package mips_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // ALUOp encodings from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type funct values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Operand forwarding select
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALU control decoder shared by the single-cycle, multicycle
// and pipelined datapaths.
// Ports:
//   alu_op      in  2  ALUOp from the main decoder
//   funct       in  6  instruction funct field (used for R-type only)
//   alu_control out 4  ALU control code; unknown R-type funct gives ALU_NOP
module alu_control_decode
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_NOP;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_OR:  alu_control = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default:   alu_control = ALU_NOP;
        endcase
      end
      default: alu_control = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus EX-side operand selection for the 5-stage
// MIPS pipeline.
// Ports:
//   clk, reset (async, active-high), stall (hold), flush (insert bubble)
//   id_*            decoded fields from ID, captured on the rising edge
//   exmem_*/memwb_* live forwarding sources from later stages
//   alu_in1/alu_in2/alu_control  ALU operands and control code
//   ex_store_data   forwarded rt value for stores
//   ex_write_reg    destination register (rd or rt, chosen at capture)
//   ex_valid, ex_reg_write, ex_mem_*  registered controls for EX/MEM
//   ex_rs, ex_rt    source specifiers for the hazard unit
//   fwd_a, fwd_b    forwarding selects (00 reg, 10 EX/MEM, 01 MEM/WB)
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic              vld_p1;
  logic              reg_write_p1;
  logic              mem_read_p1;
  logic              mem_write_p1;
  logic              mem_to_reg_p1;
  logic              alu_src_p1;
  logic [1:0]        alu_op_p1;
  logic [5:0]        funct_p1;
  logic [DATA_W-1:0] rs_data_p1;
  logic [DATA_W-1:0] rt_data_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [REG_AW-1:0] rs_p1;
  logic [REG_AW-1:0] rt_p1;
  logic [REG_AW-1:0] write_reg_p1;

  fwd_sel_e          fwd_a_sel;
  fwd_sel_e          fwd_b_sel;
  logic [DATA_W-1:0] rt_fwd;

  // $0 is hard-wired to zero, so a pending write to it must never forward.
  // EX/MEM is checked first because it holds the younger result.
  function automatic fwd_sel_e fwd_pick(
    input logic [REG_AW-1:0] src,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd
  );
    if (em_we && (em_rd != '0) && (em_rd == src))
      return FWD_EXMEM;
    else if (mw_we && (mw_rd != '0) && (mw_rd == src))
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

  function automatic logic [DATA_W-1:0] fwd_mux(
    input fwd_sel_e          sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] em_val,
    input logic [DATA_W-1:0] mw_val
  );
    case (sel)
      FWD_EXMEM: return em_val;
      FWD_MEMWB: return mw_val;
      default:   return reg_val;
    endcase
  endfunction

  // ---- ID -> EX register boundary (p1) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      alu_src_p1    <= 1'b0;
      alu_op_p1     <= '0;
      funct_p1      <= '0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      write_reg_p1  <= '0;
    end else if (!stall) begin
      // An invalid ID slot enters EX as a bubble: no side-effecting controls.
      vld_p1        <= id_valid;
      reg_write_p1  <= id_reg_write  & id_valid;
      mem_read_p1   <= id_mem_read   & id_valid;
      mem_write_p1  <= id_mem_write  & id_valid;
      mem_to_reg_p1 <= id_mem_to_reg & id_valid;
      alu_src_p1    <= id_alu_src;
      alu_op_p1     <= id_alu_op;
      funct_p1      <= id_funct;
      rs_data_p1    <= id_rs_data;
      rt_data_p1    <= id_rt_data;
      imm_p1        <= id_imm;
      rs_p1         <= id_rs;
      rt_p1         <= id_rt;
      write_reg_p1  <= id_reg_dst ? id_rd : id_rt;
    end
  end

  // ---- EX operand selection (combinational on p1 + live forwarding) ----
  always_comb begin
    fwd_a_sel = fwd_pick(rs_p1, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
    fwd_b_sel = fwd_pick(rt_p1, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
    rt_fwd    = fwd_mux(fwd_b_sel, rt_data_p1, exmem_result, memwb_data);
    alu_in1   = fwd_mux(fwd_a_sel, rs_data_p1, exmem_result, memwb_data);
    alu_in2   = alu_src_p1 ? imm_p1 : rt_fwd;
  end

  alu_control_decode u_alu_control_decode (
    .alu_op      (alu_op_p1),
    .funct       (funct_p1),
    .alu_control (alu_control)
  );

  assign fwd_a         = fwd_a_sel;
  assign fwd_b         = fwd_b_sel;
  assign ex_store_data = rt_fwd;
  assign ex_write_reg  = write_reg_p1;
  assign ex_valid      = vld_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;
  assign ex_mem_to_reg = mem_to_reg_p1;
  assign ex_rs         = rs_p1;
  assign ex_rt         = rt_p1;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic, compared against a behavioural ID/EX model.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, stall, flush, id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          exmem_reg_write, memwb_reg_write;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_data;
  logic [DW-1:0] alu_in1, alu_in2, ex_store_data;
  logic [3:0]    alu_control;
  logic [AW-1:0] ex_write_reg, ex_rs, ex_rt;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [1:0]    fwd_a, fwd_b;

  int nvec = 0;
  int nerr = 0;

  id_ex_operand_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  // Behavioural picture of what sits in EX after each edge.
  typedef struct packed {
    logic          valid, rw, mr, mw, mtr, alu_src;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [AW-1:0] rs, rt, wreg;
  } st_t;

  st_t m;

  function automatic logic [3:0] exp_ctl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    if (f == 6'b100000) return 4'b0010;
    if (f == 6'b100010) return 4'b0110;
    if (f == 6'b100100) return 4'b0000;
    if (f == 6'b100101) return 4'b0001;
    if (f == 6'b101010) return 4'b0111;
    return 4'b1111;
  endfunction

  // Which stage supplies the operand for source register r.
  function automatic logic [1:0] exp_sel(input logic [AW-1:0] r);
    if (r == 0) return 2'b00;
    if (exmem_reg_write && exmem_rd == r) return 2'b10;
    if (memwb_reg_write && memwb_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] exp_val(input logic [AW-1:0] r, input logic [DW-1:0] regval);
    logic [1:0] s;
    s = exp_sel(r);
    if (s == 2'b10) return exmem_result;
    if (s == 2'b01) return memwb_data;
    return regval;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] b;
    b = exp_val(m.rt, m.rt_data);
    chk({tag, ".ex_valid"},      32'(ex_valid),      32'(m.valid));
    chk({tag, ".ex_reg_write"},  32'(ex_reg_write),  32'(m.rw));
    chk({tag, ".ex_mem_read"},   32'(ex_mem_read),   32'(m.mr));
    chk({tag, ".ex_mem_write"},  32'(ex_mem_write),  32'(m.mw));
    chk({tag, ".ex_mem_to_reg"}, 32'(ex_mem_to_reg), 32'(m.mtr));
    chk({tag, ".ex_write_reg"},  32'(ex_write_reg),  32'(m.wreg));
    chk({tag, ".ex_rs"},         32'(ex_rs),         32'(m.rs));
    chk({tag, ".ex_rt"},         32'(ex_rt),         32'(m.rt));
    chk({tag, ".fwd_a"},         32'(fwd_a),         32'(exp_sel(m.rs)));
    chk({tag, ".fwd_b"},         32'(fwd_b),         32'(exp_sel(m.rt)));
    chk({tag, ".alu_in1"},       alu_in1,            exp_val(m.rs, m.rs_data));
    chk({tag, ".alu_in2"},       alu_in2,            m.alu_src ? m.imm : b);
    chk({tag, ".store_data"},    ex_store_data,      b);
    chk({tag, ".alu_control"},   32'(alu_control),   32'(exp_ctl(m.alu_op, m.funct)));
  endtask

  // One clock edge; the model follows the reset > flush > stall > load order.
  task automatic tick();
    st_t nx;
    nx = m;
    if (reset || flush) nx = '0;
    else if (!stall) begin
      nx.valid   = id_valid;
      nx.rw      = id_reg_write & id_valid;
      nx.mr      = id_mem_read & id_valid;
      nx.mw      = id_mem_write & id_valid;
      nx.mtr     = id_mem_to_reg & id_valid;
      nx.alu_src = id_alu_src;
      nx.alu_op  = id_alu_op;
      nx.funct   = id_funct;
      nx.rs_data = id_rs_data;
      nx.rt_data = id_rt_data;
      nx.imm     = id_imm;
      nx.rs      = id_rs;
      nx.rt      = id_rt;
      nx.wreg    = id_reg_dst ? id_rd : id_rt;
    end
    @(posedge clk);
    m = nx;
    @(negedge clk);
  endtask

  task automatic rand_id();
    logic [5:0] fl [6];
    fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100;
    fl[3] = 6'b100101; fl[4] = 6'b101010; fl[5] = 6'($urandom);
    id_valid      = ($urandom_range(0, 4) != 0);
    id_rs_data    = $urandom;
    id_rt_data    = $urandom;
    id_imm        = $urandom;
    id_rs         = AW'($urandom_range(0, 3));
    id_rt         = AW'($urandom_range(0, 3));
    id_rd         = AW'($urandom_range(0, 31));
    id_alu_op     = 2'($urandom);
    id_funct      = fl[$urandom_range(0, 5)];
    id_alu_src    = 1'($urandom);
    id_reg_dst    = 1'($urandom);
    id_reg_write  = 1'($urandom);
    id_mem_read   = 1'($urandom);
    id_mem_write  = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
  endtask

  task automatic rand_fwd();
    exmem_reg_write = 1'($urandom);
    exmem_rd        = AW'($urandom_range(0, 3));
    exmem_result    = $urandom;
    memwb_reg_write = 1'($urandom);
    memwb_rd        = AW'($urandom_range(0, 3));
    memwb_data      = $urandom;
  endtask

  task automatic fwd_off();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic load(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm,
                      input logic [1:0] op, input logic [5:0] f, input logic src,
                      input logic dst, input logic rw, input logic mw);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = a; id_rt_data = b; id_imm = imm; id_alu_op = op; id_funct = f;
    id_alu_src = src; id_reg_dst = dst; id_reg_write = rw;
    id_mem_read = 0; id_mem_write = mw; id_mem_to_reg = 0;
  endtask

  logic [DW-1:0] held;

  initial begin
    reset = 1; stall = 0; flush = 0;
    load(0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 0, 0);
    id_valid = 0;
    fwd_off();
    m = '0;
    #1;
    check_all("reset");
    chk("reset.alu_control", 32'(alu_control), 32'h2);
    @(negedge clk);
    reset = 0;

    // Fill with something, then reset between edges while stalled.
    rand_id();
    tick();
    stall = 1;
    #2 reset = 1;
    m = '0;
    #1;
    check_all("async_reset");
    chk("async_reset.ex_valid", 32'(ex_valid), 32'h0);
    chk("async_reset.alu_in1", alu_in1, 32'h0);
    @(negedge clk);
    reset = 0; stall = 0;

    // R-type add, no forwarding.
    load(1, 2, 4, 32'd5, 32'd7, 32'h0, 2'b10, 6'b100000, 0, 1, 1, 0);
    tick();
    #1;
    check_all("radd");
    chk("radd.alu_in1", alu_in1, 32'd5);
    chk("radd.alu_in2", alu_in2, 32'd7);
    chk("radd.alu_control", 32'(alu_control), 32'h2);
    chk("radd.fwd_a", 32'(fwd_a), 32'h0);

    // rs = 3 matched by both EX/MEM and MEM/WB.
    load(3, 1, 5, 32'h11, 32'h22, 32'h0, 2'b10, 6'b100010, 0, 1, 1, 0);
    tick();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h64;
    memwb_reg_write = 1; memwb_rd = 3; memwb_data = 32'h99;
    #1;
    check_all("fwd_both");
    chk("fwd_both.alu_in1", alu_in1, 32'h64);
    chk("fwd_both.fwd_a", 32'(fwd_a), 32'h2);
    exmem_reg_write = 0;
    #1;
    check_all("fwd_memwb");
    chk("fwd_memwb.alu_in1", alu_in1, 32'h99);
    chk("fwd_memwb.fwd_a", 32'(fwd_a), 32'h1);
    @(negedge clk);
    fwd_off();

    // Writer targets $0: never forwarded.
    load(0, 0, 2, 32'h1234, 32'h5678, 32'h0, 2'b00, 6'd0, 0, 0, 1, 0);
    tick();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'hFFFF;
    #1;
    check_all("zero_reg");
    chk("zero_reg.alu_in1", alu_in1, 32'h1234);
    @(negedge clk);
    fwd_off();

    // sw: immediate on in2, forwarded rt on store data.
    load(2, 6, 0, 32'h40, 32'h1, 32'd8, 2'b00, 6'd0, 1, 0, 0, 1);
    tick();
    exmem_reg_write = 1; exmem_rd = 6; exmem_result = 32'hABCD;
    #1;
    check_all("sw");
    chk("sw.alu_in2", alu_in2, 32'd8);
    chk("sw.store_data", ex_store_data, 32'hABCD);
    chk("sw.ex_mem_write", 32'(ex_mem_write), 32'h1);
    @(negedge clk);
    fwd_off();

    // Stall for three edges with changing ID inputs.
    held = alu_in1;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      #1;
      check_all("stall");
      chk("stall.alu_in1_held", alu_in1, held);
    end

    // Flush and stall together: flush wins.
    flush = 1;
    load(1, 1, 1, 32'h5, 32'h5, 32'h5, 2'b10, 6'd0, 0, 1, 1, 1);
    tick();
    flush = 0; stall = 0;
    #1;
    check_all("flush");
    chk("flush.ex_valid", 32'(ex_valid), 32'h0);
    chk("flush.ex_reg_write", 32'(ex_reg_write), 32'h0);
    chk("flush.ex_mem_write", 32'(ex_mem_write), 32'h0);

    // Unknown R-type funct.
    load(1, 2, 3, 32'h1, 32'h2, 32'h0, 2'b10, 6'b000000, 0, 1, 1, 0);
    tick();
    #1;
    check_all("nop_funct");
    chk("nop_funct.alu_control", 32'(alu_control), 32'hF);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rand_id();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      tick();
      rand_fwd();
      #1;
      check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
